// File: rtl/fbtxt_console.sv
// Byte-stream writer for the 40x25 text cell RAM: one printable byte per 2 cycles, CR/LF/BS in the accept cycle.
// Scroll and clear run as cell-per-cycle sweeps while charReady is held low; the source holds its byte until accepted.
module fbtxt_console #(
    parameter int COLS = 40,
    parameter int ROWS = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  charIn,
    input  logic        charValid,
    output logic        charReady,
    input  logic [5:0]  attrClrA,
    input  logic [5:0]  attrClrB,
    output logic        cellWrEn,
    output logic [13:0] cellWrIx,
    output logic [31:0] cellWrData,
    output logic [13:0] cellRdIx,
    input  logic [31:0] cellRdData,
    output logic [5:0]  curX,
    output logic [4:0]  curY,
    output logic        busy
);

    localparam logic [13:0] CELLS     = 14'(ROWS * COLS);
    localparam logic [13:0] LAST_ROW  = 14'((ROWS - 1) * COLS);
    localparam logic [13:0] COPY_LAST = 14'((ROWS - 1) * COLS - 1);
    localparam logic [13:0] COLS14    = 14'(COLS);
    localparam logic [5:0]  XMAX      = 6'(COLS - 1);
    localparam logic [4:0]  YMAX      = 5'(ROWS - 1);
    localparam logic [31:0] BLANK     = 32'h003F_0020;

    typedef enum logic [2:0] {CLRALL, IDLE, PUT, SCRL, CLRLN} stateT;

    stateT       state, stateNext;
    logic [13:0] cnt, cntNext;
    logic [5:0]  xNext;
    logic [4:0]  yNext;
    logic        wrEnNext, copySel, copyNext;
    logic [13:0] wrIxNext, rdIxNext;
    logic [31:0] wrDataQ, wrDataNext;

    // Copy writes carry the RAM read data straight through; the select itself is registered.
    assign cellWrData = copySel ? cellRdData : wrDataQ;

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        xNext      = curX;
        yNext      = curY;
        wrEnNext   = 1'b0;
        wrIxNext   = cellWrIx;
        wrDataNext = wrDataQ;
        copyNext   = 1'b0;
        rdIxNext   = cellRdIx;
        case (state)
            CLRALL, CLRLN: begin
                // cnt runs one past the last cell so IDLE lines up with the final write being visible
                if (cnt < CELLS) begin
                    wrEnNext   = 1'b1;
                    wrIxNext   = cnt;
                    wrDataNext = BLANK;
                    cntNext    = cnt + 14'd1;
                end else begin
                    stateNext = IDLE;
                end
            end
            IDLE: begin
                if (charValid) begin
                    if (charIn >= 8'h20 && charIn <= 8'h7E) begin
                        wrEnNext   = 1'b1;
                        wrIxNext   = 14'(curY) * COLS14 + 14'(curX);
                        wrDataNext = {4'b0000, attrClrB, attrClrA, 8'h00, charIn};
                        stateNext  = PUT;
                    end else begin
                        case (charIn)
                            8'h0D: xNext = 6'd0;
                            8'h0A: begin
                                xNext = 6'd0;
                                if (curY < YMAX) begin
                                    yNext = curY + 5'd1;
                                end else begin
                                    stateNext = SCRL;
                                    cntNext   = 14'd0;
                                    rdIxNext  = COLS14;
                                end
                            end
                            8'h08: if (curX != 6'd0) xNext = curX - 6'd1;
                            8'h0C: begin
                                xNext     = 6'd0;
                                yNext     = 5'd0;
                                stateNext = CLRALL;
                                cntNext   = 14'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                if (curX < XMAX) begin
                    xNext     = curX + 6'd1;
                    stateNext = IDLE;
                end else begin
                    xNext = 6'd0;
                    if (curY < YMAX) begin
                        yNext     = curY + 5'd1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = SCRL;
                        cntNext   = 14'd0;
                        rdIxNext  = COLS14;
                    end
                end
            end
            SCRL: begin
                wrEnNext = 1'b1;
                wrIxNext = cnt;
                copyNext = 1'b1;
                cntNext  = cnt + 14'd1;
                if (cnt == COPY_LAST) begin
                    stateNext = CLRLN;
                    cntNext   = LAST_ROW;
                end else begin
                    rdIxNext = cnt + COLS14 + 14'd1;
                end
            end
            default: stateNext = CLRALL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= CLRALL;
            cnt       <= 14'd0;
            curX      <= 6'd0;
            curY      <= 5'd0;
            cellWrEn  <= 1'b0;
            cellWrIx  <= 14'd0;
            wrDataQ   <= 32'd0;
            copySel   <= 1'b0;
            cellRdIx  <= 14'd0;
            charReady <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            curX      <= xNext;
            curY      <= yNext;
            cellWrEn  <= wrEnNext;
            cellWrIx  <= wrIxNext;
            wrDataQ   <= wrDataNext;
            copySel   <= copyNext;
            cellRdIx  <= rdIxNext;
            charReady <= (stateNext == IDLE);
            busy      <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_fbtxt_console.sv
// Directed bench for fbtxt_console with a cell-RAM model and an expected-screen model.
module tb_fbtxt_console;

    localparam logic [31:0] BLANK = 32'h003F_0020;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  charIn;
    logic        charValid;
    logic        charReady;
    logic [5:0]  attrClrA;
    logic [5:0]  attrClrB;
    logic        cellWrEn;
    logic [13:0] cellWrIx;
    logic [31:0] cellWrData;
    logic [13:0] cellRdIx;
    logic [31:0] cellRdData;
    logic [5:0]  curX;
    logic [4:0]  curY;
    logic        busy;

    always #5 clock = ~clock;

    fbtxt_console dut (
        .clock(clock), .reset(reset), .charIn(charIn), .charValid(charValid),
        .charReady(charReady), .attrClrA(attrClrA), .attrClrB(attrClrB),
        .cellWrEn(cellWrEn), .cellWrIx(cellWrIx), .cellWrData(cellWrData),
        .cellRdIx(cellRdIx), .cellRdData(cellRdData), .curX(curX), .curY(curY),
        .busy(busy)
    );

    logic [31:0] mem  [1000];
    logic [31:0] exp  [1000];
    logic [31:0] snap [1000];
    int checks = 0;
    int failures = 0;
    int ex, ey, bad;

    always @(posedge clock) begin
        if (cellWrEn && cellWrIx < 14'd1000) mem[cellWrIx[9:0]] <= cellWrData;
        cellRdData <= (cellRdIx < 14'd1000) ? mem[cellRdIx[9:0]] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic modelScroll();
        for (int i = 0; i < 960; i++) exp[i] = exp[i + 40];
        for (int i = 960; i < 1000; i++) exp[i] = BLANK;
    endtask

    task automatic modelByte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp[ey * 40 + ex] = {4'b0000, attrClrB, attrClrA, 8'h00, b};
            if (ex < 39) ex++;
            else begin
                ex = 0;
                if (ey < 24) ey++; else modelScroll();
            end
        end else if (b == 8'h0D) ex = 0;
        else if (b == 8'h0A) begin
            ex = 0;
            if (ey < 24) ey++; else modelScroll();
        end else if (b == 8'h08) begin
            if (ex > 0) ex--;
        end else if (b == 8'h0C) begin
            ex = 0; ey = 0;
            for (int i = 0; i < 1000; i++) exp[i] = BLANK;
        end
    endtask

    task automatic waitReady();
        int g = 0;
        while (charReady !== 1'b1 && g < 3000) begin
            @(negedge clock);
            g++;
        end
        if (g >= 3000) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout observed charReady=%b expected 1", charReady);
        end
    endtask

    // Returns at the negedge just after the accepting edge.
    task automatic sendByte(input logic [7:0] b);
        waitReady();
        charIn = b;
        charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        modelByte(b);
    endtask

    task automatic screenCheck(input string tag);
        int nbad = 0;
        for (int i = 0; i < 1000; i++) if (mem[i] !== exp[i]) nbad++;
        check(tag, nbad, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; charIn = 8'h00; charValid = 1'b0;
        attrClrA = 6'h3F; attrClrB = 6'h00;
        ex = 0; ey = 0;
        for (int i = 0; i < 1000; i++) exp[i] = BLANK;
        @(negedge clock);
        @(negedge clock);
        check("rst_wren", cellWrEn, 0);
        check("rst_ready", charReady, 0);
        check("rst_busy", busy, 1);
        check("rst_cursor", {curY, curX}, 0);
        check("rst_wrix_rdix", {cellWrIx, cellRdIx}, 0);
        check("rst_wrdata", cellWrData, 0);

        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (!(cellWrEn === 1'b1 && cellWrIx === 14'(k) && cellWrData === BLANK && charReady === 1'b0)) bad++;
        end
        check("clrall_seq", bad, 0);
        @(negedge clock);
        check("clrall_done_ready", charReady, 1);
        check("clrall_done_wren", cellWrEn, 0);
        check("clrall_done_busy", busy, 0);
        screenCheck("screen_after_clear");

        // 'A' at the origin
        charIn = 8'h41; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        check("A_wren", cellWrEn, 1);
        check("A_ix", cellWrIx, 0);
        check("A_data", cellWrData, 32'h003F_0041);
        check("A_ready_low", charReady, 0);
        modelByte(8'h41);
        @(negedge clock);
        check("A_ready_back", charReady, 1);
        check("A_wren_off", cellWrEn, 0);
        check("A_curx", curX, 1);

        sendByte(8'h0A);
        check("lf_ready_kept", charReady, 1);
        check("lf_cursor", {curY, curX}, {5'd1, 6'd0});
        sendByte(8'h0A);
        sendByte(8'h0A);
        for (int n = 0; n < 39; n++) sendByte(8'(65 + n % 26));
        waitReady();
        check("preZ_cursor", {curY, curX}, {5'd3, 6'd39});

        attrClrA = 6'h15; attrClrB = 6'h2A;
        charIn = 8'h5A; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        check("Z_ix", cellWrIx, 159);
        check("Z_data", cellWrData, 32'h0A95_005A);
        modelByte(8'h5A);
        @(negedge clock);
        check("Z_cursor", {curY, curX}, {5'd4, 6'd0});

        sendByte(8'h08);
        check("bs0_wren", cellWrEn, 0);
        check("bs0_cursor", {curY, curX}, {5'd4, 6'd0});
        sendByte(8'h78);
        sendByte(8'h79);
        sendByte(8'h08);
        check("bs_curx", curX, 1);
        sendByte(8'h0D);
        check("cr_cursor", {curY, curX}, {5'd4, 6'd0});
        sendByte(8'h07);
        check("ignored_state", {cellWrEn, busy, charReady}, 3'b001);
        check("ignored_cursor", {curY, curX}, {5'd4, 6'd0});

        for (int n = 0; n < 839; n++) begin
            attrClrA = 6'(n);
            attrClrB = 6'(n / 7);
            sendByte(8'(33 + n % 90));
        end
        waitReady();
        check("prehash_cursor", {curY, curX}, {5'd24, 6'd39});
        screenCheck("screen_before_scroll");

        // '#' at the bottom-right cell triggers the scroll
        attrClrA = 6'h3F; attrClrB = 6'h00;
        charIn = 8'h23; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        check("hash_ix", cellWrIx, 999);
        check("hash_data", cellWrData, 32'h003F_0023);
        exp[999] = 32'h003F_0023;
        for (int i = 0; i < 1000; i++) snap[i] = exp[i];
        @(negedge clock);
        check("scrl_prime_wren", cellWrEn, 0);
        check("scrl_prime_busy", busy, 1);
        check("scrl_prime_rdix", cellRdIx, 40);
        bad = 0;
        for (int i = 0; i < 960; i++) begin
            @(negedge clock);
            if (!(cellWrEn === 1'b1 && cellWrIx === 14'(i) && cellWrData === snap[i + 40] && busy === 1'b1)) bad++;
        end
        check("scrl_copy", bad, 0);
        bad = 0;
        for (int i = 960; i < 1000; i++) begin
            @(negedge clock);
            if (!(cellWrEn === 1'b1 && cellWrIx === 14'(i) && cellWrData === BLANK && charReady === 1'b0)) bad++;
        end
        check("scrl_clear", bad, 0);
        @(negedge clock);
        check("scrl_done_ready", charReady, 1);
        check("scrl_done_cursor", {curY, curX}, {5'd24, 6'd0});
        modelScroll();
        ex = 0; ey = 24;
        screenCheck("screen_after_scroll");

        // LF on the last row scrolls; reset lands mid-copy
        for (int i = 0; i < 1000; i++) snap[i] = exp[i];
        charIn = 8'h0A; charValid = 1'b1;
        @(negedge clock);
        charValid = 1'b0;
        check("lfscrl_prime", {cellWrEn, charReady, busy}, 3'b001);
        check("lfscrl_rdix", cellRdIx, 40);
        bad = 0;
        for (int i = 0; i <= 500; i++) begin
            @(negedge clock);
            if (!(cellWrEn === 1'b1 && cellWrIx === 14'(i) && cellWrData === snap[i + 40])) bad++;
        end
        check("lfscrl_copy_to_500", bad, 0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_wren", cellWrEn, 0);
        check("abort_outputs", {charReady, busy, curY, curX}, {1'b0, 1'b1, 11'd0});
        @(negedge clock);
        check("abort_wren_hold", cellWrEn, 0);
        reset = 1'b0;
        @(negedge clock);
        check("restart_write", {cellWrEn, cellWrIx}, {1'b1, 14'd0});
        check("restart_data", cellWrData, BLANK);
        for (int i = 0; i < 1000; i++) exp[i] = BLANK;
        ex = 0; ey = 0;
        waitReady();
        screenCheck("screen_after_restart");

        // Form feed wipes the screen and homes the cursor
        sendByte(8'h51);
        sendByte(8'h51);
        sendByte(8'h0C);
        check("ff_busy", {busy, charReady}, 2'b10);
        check("ff_cursor", {curY, curX}, 0);
        waitReady();
        screenCheck("screen_after_ff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
